// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcode encodings, FSM states, strobe one-hots.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam logic [2:0] STROBE_A  = 3'b001;
  localparam logic [2:0] STROBE_B  = 3'b010;
  localparam logic [2:0] STROBE_OP = 3'b100;

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StWaitRes,
    StSend
  } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte-in / result-out handshake bundle between a byte source/sink and the command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned NB_DATA = 8
) ();

  logic [NB_DATA-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

endinterface

// File: rtl/alu_opcode_legal.sv
// Combinational opcode legality check: upper byte bits zero and opcode field in the supported set.
module alu_opcode_legal
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_OPCODE = 6
) (
  input  logic [NB_DATA-1:0] i_opcode,
  output logic               o_legal
);

  logic [NB_OPCODE-1:0] field;
  logic                 hi_zero;

  assign field   = i_opcode[NB_OPCODE-1:0];
  assign hi_zero = (i_opcode[NB_DATA-1:NB_OPCODE] == '0);

  assign o_legal = hi_zero && (field inside {NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB),
                                             NB_OPCODE'(OP_AND), NB_OPCODE'(OP_OR),
                                             NB_OPCODE'(OP_XOR), NB_OPCODE'(OP_SRA),
                                             NB_OPCODE'(OP_SRL), NB_OPCODE'(OP_NOR)});

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives the ALU controller's switch/strobe load port from an A,B,OP byte stream and returns the result.
// Optional opcode filtering is enabled by defining ALU_OPCODE_CHECK_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NB_OPCODE    = 6,
  parameter int unsigned N_PULSADORES = 3,
  parameter int unsigned RESULT_WAIT  = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  alu_cmd_sequencer_if.slave      bus,
  output logic [NB_DATA-1:0]      o_switches,
  output logic [N_PULSADORES-1:0] o_pulsadores,
  input  logic [NB_DATA-1:0]      i_result,
  output logic                    o_op_error
);

  localparam int unsigned CntW = $clog2(RESULT_WAIT + 1);

  if (NB_OPCODE > NB_DATA) begin : g_bad_opcode_width
    $error("NB_OPCODE must not exceed NB_DATA");
  end

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NB_DATA-1:0]      switches_q, switches_d;
  logic [N_PULSADORES-1:0] pulsadores_q, pulsadores_d;
  logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    op_error_q, op_error_d;
  logic                    rx_ready;
  logic                    rx_fire;
  logic                    op_legal;

`ifdef ALU_OPCODE_CHECK_EN
  alu_opcode_legal #(
    .NB_DATA  (NB_DATA),
    .NB_OPCODE(NB_OPCODE)
  ) u_opcode_legal (
    .i_opcode(bus.rx_data),
    .o_legal (op_legal)
  );
`else
  assign op_legal = 1'b1;
`endif

  assign rx_ready = (state_q inside {StWaitA, StWaitB, StWaitOp});
  assign rx_fire  = bus.rx_valid & rx_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    switches_d   = switches_q;
    pulsadores_d = '0;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    op_error_d   = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (rx_fire) begin
          switches_d   = bus.rx_data;
          pulsadores_d = N_PULSADORES'(STROBE_A);
          state_d      = StWaitB;
        end
      end
      StWaitB: begin
        if (rx_fire) begin
          switches_d   = bus.rx_data;
          pulsadores_d = N_PULSADORES'(STROBE_B);
          state_d      = StWaitOp;
        end
      end
      StWaitOp: begin
        if (rx_fire) begin
          if (op_legal) begin
            switches_d   = bus.rx_data;
            pulsadores_d = N_PULSADORES'(STROBE_OP);
            cnt_d        = CntW'(RESULT_WAIT);
            state_d      = StWaitRes;
          end else begin
            // Dropped opcode: A/B already loaded in the controller are simply left unused.
            op_error_d = 1'b1;
            state_d    = StWaitA;
          end
        end
      end
      StWaitRes: begin
        if (cnt_q == '0) begin
          tx_data_d  = i_result;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSend: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StWaitA;
        end
      end
      default: state_d = StWaitA;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StWaitA;
      cnt_q        <= '0;
      switches_q   <= '0;
      pulsadores_q <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      op_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      switches_q   <= switches_d;
      pulsadores_q <= pulsadores_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      op_error_q   <= op_error_d;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign o_switches   = switches_q;
  assign o_pulsadores = pulsadores_q;
  assign o_op_error   = op_error_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a strobe-latching controller model and result scoreboard.
module tb_alu_cmd_sequencer;

  localparam int unsigned RW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic [2:0] pul;
  logic [7:0] res;
  logic       op_err;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.NB_DATA(8)) bus_if ();

  alu_cmd_sequencer #(
    .NB_DATA     (8),
    .NB_OPCODE   (6),
    .N_PULSADORES(3),
    .RESULT_WAIT (RW)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .bus         (bus_if),
    .o_switches  (sw),
    .o_pulsadores(pul),
    .i_result    (res),
    .o_op_error  (op_err)
  );

  // Controller model: latch switches on strobes, compute result combinationally.
  logic [7:0] ctl_a = '0, ctl_b = '0;
  logic [5:0] ctl_op = '0;

  always @(posedge clk) begin
    if (pul[0]) ctl_a <= sw;
    if (pul[1]) ctl_b <= sw;
    if (pul[2]) ctl_op <= sw[5:0];
  end

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      6'b100111: return ~(a | b);
      default:   return 8'h00;
    endcase
  endfunction

  assign res = alu_f(ctl_a, ctl_b, ctl_op);

  int strobe_cnt [3];
  int bad_strobe = 0;
  int err_cnt    = 0;
  int hs_cnt     = 0;

  initial begin
    for (int i = 0; i < 3; i++) strobe_cnt[i] = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pul != 3'b000) begin
        if (!$onehot(pul)) bad_strobe++;
        for (int i = 0; i < 3; i++) if (pul[i]) strobe_cnt[i]++;
      end
      if (op_err) err_cnt++;
      if (bus_if.tx_valid && bus_if.tx_ready) hs_cnt++;
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
  task automatic send_byte(input string tag, input logic [7:0] d, input logic [2:0] exp_strobe,
                           input logic [7:0] exp_sw);
    int n;
    n = 0;
    bus_if.rx_data  = d;
    bus_if.rx_valid = 1'b1;
    while (bus_if.rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, bus_if.rx_ready, 1'b1);
    tick();
    bus_if.rx_valid = 1'b0;
    check({tag, "_strobe"}, pul, exp_strobe);
    check({tag, "_switches"}, sw, exp_sw);
  endtask

  task automatic wait_result(input string tag, output int lat);
    logic [7:0] exp;
    lat = 0;
    while (bus_if.tx_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_tx_valid"}, bus_if.tx_valid, 1'b1);
    checks++;
    assert (exp_q.size() != 0)
    else begin
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_tx_data"}, bus_if.tx_data, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  int lat;
  int hs0, err0;
  int s0 [3];

  initial begin
    rst_n           = 1'b0;
    bus_if.rx_data  = '0;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b0;
    #1;
    check("rst_switches", sw, 8'h00);
    check("rst_strobe", pul, 3'b000);
    check("rst_tx_data", bus_if.tx_data, 8'h00);
    check("rst_tx_valid", bus_if.tx_valid, 1'b0);
    check("rst_op_error", op_err, 1'b0);
    check("rst_rx_ready", bus_if.rx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD with sink always ready
    bus_if.tx_ready = 1'b1;
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) s0[i] = strobe_cnt[i];
    send_byte("t1_a", 8'h05, 3'b001, 8'h05);
    send_byte("t1_b", 8'h03, 3'b010, 8'h03);
    exp_q.push_back(8'h08);
    send_byte("t1_op", 8'h20, 3'b100, 8'h20);
    wait_result("t1", lat);
    check("t1_latency", lat, RW + 1);
    check("t1_rx_ready_busy", bus_if.rx_ready, 1'b0);
    tick();
    check("t1_tx_clear", bus_if.tx_valid, 1'b0);
    check("t1_back_idle", bus_if.rx_ready, 1'b1);
    check("t1_handshakes", hs_cnt - hs0, 1);
    for (int i = 0; i < 3; i++) check("t1_strobe_count", strobe_cnt[i] - s0[i], 1);

    // SUB with sink back-pressure and a pushy source
    bus_if.tx_ready = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) s0[i] = strobe_cnt[i];
    send_byte("t2_a", 8'h0C, 3'b001, 8'h0C);
    send_byte("t2_b", 8'h0A, 3'b010, 8'h0A);
    exp_q.push_back(8'h02);
    send_byte("t2_op", 8'h22, 3'b100, 8'h22);
    wait_result("t2", lat);
    bus_if.rx_data  = 8'h55;
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", bus_if.tx_valid, 1'b1);
      check("t2_hold_data", bus_if.tx_data, 8'h02);
      check("t2_hold_rx_ready", bus_if.rx_ready, 1'b0);
    end
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b1;
    tick();
    check("t2_tx_clear", bus_if.tx_valid, 1'b0);
    check("t2_handshakes", hs_cnt - hs0, 1);
    for (int i = 0; i < 3; i++) check("t2_strobe_count", strobe_cnt[i] - s0[i], 1);

    // SRA with idle gaps between bytes
    for (int i = 0; i < 3; i++) s0[i] = strobe_cnt[i];
    send_byte("t3_a", 8'h80, 3'b001, 8'h80);
    tick();
    check("t3_strobe_one_cycle", pul, 3'b000);
    check("t3_switches_hold", sw, 8'h80);
    tick();
    tick();
    send_byte("t3_b", 8'h02, 3'b010, 8'h02);
    repeat (3) tick();
    exp_q.push_back(8'hE0);
    send_byte("t3_op", 8'h03, 3'b100, 8'h03);
    wait_result("t3", lat);
    tick();
    for (int i = 0; i < 3; i++) check("t3_strobe_count", strobe_cnt[i] - s0[i], 1);

`ifdef ALU_OPCODE_CHECK_EN
    // Illegal opcode is dropped, then a fresh sequence runs
    hs0  = hs_cnt;
    err0 = err_cnt;
    send_byte("t4_a", 8'h01, 3'b001, 8'h01);
    send_byte("t4_b", 8'h02, 3'b010, 8'h02);
    send_byte("t4_bad_op", 8'h3F, 3'b000, 8'h02);
    check("t4_op_error", op_err, 1'b1);
    tick();
    check("t4_op_error_pulse", op_err, 1'b0);
    check("t4_rx_ready", bus_if.rx_ready, 1'b1);
    check("t4_no_tx", bus_if.tx_valid, 1'b0);
    send_byte("t4_a2", 8'h07, 3'b001, 8'h07);
    send_byte("t4_b2", 8'h01, 3'b010, 8'h01);
    exp_q.push_back(8'h06);
    send_byte("t4_op2", 8'h22, 3'b100, 8'h22);
    wait_result("t4", lat);
    tick();
    check("t4_error_count", err_cnt - err0, 1);
    check("t4_handshakes", hs_cnt - hs0, 1);
`else
    // Any opcode byte is loaded when filtering is off
    err0 = err_cnt;
    send_byte("t6_a", 8'h01, 3'b001, 8'h01);
    send_byte("t6_b", 8'h02, 3'b010, 8'h02);
    exp_q.push_back(8'h00);
    send_byte("t6_op", 8'hFF, 3'b100, 8'hFF);
    check("t6_op_error", op_err, 1'b0);
    wait_result("t6", lat);
    tick();
    check("t6_error_count", err_cnt - err0, 0);
`endif

    // Asynchronous reset in the middle of a sequence
    send_byte("t5_a", 8'h44, 3'b001, 8'h44);
    send_byte("t5_b", 8'h55, 3'b010, 8'h55);
    tick();
    rst_n = 1'b0;
    #2;
    check("t5_rst_switches", sw, 8'h00);
    check("t5_rst_strobe", pul, 3'b000);
    check("t5_rst_tx_data", bus_if.tx_data, 8'h00);
    check("t5_rst_tx_valid", bus_if.tx_valid, 1'b0);
    check("t5_rst_op_error", op_err, 1'b0);
    check("t5_rst_rx_ready", bus_if.rx_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    send_byte("t5_a2", 8'h11, 3'b001, 8'h11);
    send_byte("t5_b2", 8'h22, 3'b010, 8'h22);
    exp_q.push_back(8'h33);
    send_byte("t5_op2", 8'h20, 3'b100, 8'h20);
    wait_result("t5", lat);
    tick();

    check("strobe_onehot", bad_strobe, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
